joy_conditioner: RTL
====================

// Module: joy_conditioner
// PURPOSE
// - Conditions both raw joystick ports between the MCP23S17 SPI poller and the Minimig core JOYA/JOYB inputs.
// - Per-bit debounce, up/down and left/right conflict cleaning, optional per-port autofire, and port swap.
// - Outputs the 7-bit active-low vectors the core expects.
// - Bit order is the same on inputs and outputs: [5:0] = fire2, fire, up, down, left, right.
// PARAMETERS
// - DEBOUNCE_CYCLES  28375  clocks an input bit must hold a new level before it is accepted (1 ms at 28.375 MHz); min 2.
// - AF_HALF          709375  clocks per autofire half-period (25 ms, i.e. 20 Hz); min 2.
// PORTS
// - clk          in   1  system clock (clk_28 domain); the only clock.
// - rst          in   1  synchronous reset, active-high.
// - joya_in      in   6  raw port A bits from the poller, active-low (0 = pressed).
// - joyb_in      in   6  raw port B bits, active-low.
// - autofire_en  in   2  [0] port A, [1] port B; autofire applies to fire (bit 4) only.
// - swap         in   1  1 = exchange the conditioned ports on the outputs.
// - joya_out     out  7  to core JOYA, active-low; bit 6 tied 1.
// - joyb_out     out  7  to core JOYB, active-low; bit 6 tied 1.
// - changed      out  1  one-cycle pulse whenever {joya_out,joyb_out} differs from its previous value.
// BEHAVIOUR
// - Reset values
//   - joya_out and joyb_out = 7'h7F; changed = 0.
//   - Debounced state = 6'h3F per port; all counters = 0.
// - Input stage: joya_in and joyb_in are registered once, with no synchroniser (same clock domain).
// - Debounce, per bit
//   - If the registered bit equals the stable bit, the counter clears.
//   - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable bit takes the new value and the counter clears.
//   - A glitch shorter than DEBOUNCE_CYCLES never reaches the stable state.
// - Conflict cleaning, combinational on the stable bits
//   - up and down both pressed -> both reported released.
//   - left and right both pressed -> both reported released.
//   - Fire bits are not affected.
// - Autofire, per port: a phase counter plus a phase bit.
//   - Fire press edge (stable fire goes 1->0) while autofire_en is set: counter = 0, phase = PRESS, so the first shot is immediate.
//   - While stable fire is held: counter counts to AF_HALF-1, then clears and toggles phase.
//   - Output fire = 0 when phase = PRESS, 1 when phase = RELEASE.
//   - Fire released, or autofire_en low: output fire follows stable fire, and phase is forced to PRESS.
//   - autofire_en rising while fire is already held: the counter restarts from 0 with phase = PRESS.
// - Swap and output register
//   - Outputs are registered: joya_out = {1'b1, swap ? condB : condA}; joyb_out likewise with the ports exchanged.
//   - swap takes effect on the next clock, with no debounce.
// - changed is registered, and asserts on the cycle after the output register updates to a new value.
// - Latency: a level applied to joya_in from cycle 0 and held appears on joya_out at cycle DEBOUNCE_CYCLES+2.
// - Reset mid-debounce or mid-autofire: everything returns to reset values on the next clock. No partial count survives reset.
// - Simultaneous change of several bits: each bit debounces independently, so outputs may update on different cycles.
// STRUCTURE
// - Package joy_pkg holds:
//   - bit index localparams JOY_RIGHT=0, JOY_LEFT=1, JOY_DOWN=2, JOY_UP=3, JOY_FIRE=4, JOY_FIRE2=5;
//   - JOY_IDLE = 7'h7F;
//   - the autofire phase encoding (PRESS=0, RELEASE=1).
// - Sub-module joy_port_cond
//   - One port: input register, six debouncers, conflict cleaning, autofire.
//   - Parameters DEBOUNCE_CYCLES and AF_HALF; instantiated twice.
//   - The top level holds only the swap, the output register and changed.
// TESTING (bench params DEBOUNCE_CYCLES=4, AF_HALF=8)
// - Reset release: joya_out = joyb_out = 7'h7F and changed = 0 on the first cycle after rst deasserts.
// - Debounce
//   - joya_in = 6'h3E (right) held from cycle 0 -> joya_out = 7'h7E at cycle 6; changed pulses once at cycle 7.
//   - A 3-cycle pulse of 6'h3E -> joya_out stays 7'h7F and changed never pulses.
// - Conflict: joyb_in = 6'h33 (up+down pressed) stable -> joyb_out = 7'h7F.
// - Autofire: autofire_en = 2'b01, joya_in = 6'h2F held.
//   - joya_out[4] = 0 for 8 cycles, then 1 for 8, repeating.
//   - Releasing fire -> joya_out[4] = 1 after debounce, and the phase restarts at PRESS on the next press.
// - Swap: joya_in = 6'h3D, joyb_in = 6'h3B, both stable; toggle swap -> outputs 7'h7B / 7'h7D one cycle later, with one changed pulse.
// - Reset mid-count: assert rst 2 cycles into a debounce -> outputs 7'h7F. After release, the full DEBOUNCE_CYCLES+2 latency applies again.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared definitions for the joystick conditioning path.
// Bit order on every 6-bit joystick vector: [5:0] = fire2, fire, up, down, left, right.
// All joystick vectors are active-low (0 = pressed).
package joy_pkg;

  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_FIRE  = 4;
  localparam int unsigned JOY_FIRE2 = 5;

  // Core-facing idle vector: bit 6 is tied high, all buttons released.
  localparam logic [6:0] JOY_IDLE = 7'h7F;

  // Autofire phase; the encoding equals the active-low fire level it produces.
  typedef enum logic {
    AfPress   = 1'b0,
    AfRelease = 1'b1
  } af_phase_e;

endpackage

// File: rtl/joy_port_cond.sv
// Conditions one raw joystick port.
// Pipeline: input register -> per-bit debounce -> up/down and left/right conflict
// cleaning -> optional autofire on the fire bit.
// Ports:
//   clk     in   system clock (clk_28 domain)
//   rst     in   synchronous reset, active-high
//   joy_in  in   6 raw port bits from the poller, active-low
//   af_en   in   autofire enable for this port
//   cond    out  6 conditioned bits, active-low (combinational from registered state)
module joy_port_cond
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 28375,
  parameter int unsigned AF_HALF         = 709375
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] joy_in,
  input  logic       af_en,
  output logic [5:0] cond
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AfW = $clog2(AF_HALF);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AfW-1:0] AfLast = AfW'(AF_HALF - 1);

  logic [5:0]     in_q;
  logic [5:0]     stable_q, stable_d;
  logic [DbW-1:0] db_cnt_q [6];
  logic [DbW-1:0] db_cnt_d [6];
  logic [AfW-1:0] af_cnt_q, af_cnt_d;
  af_phase_e      af_phase_q, af_phase_d;
  logic [5:0]     clean;

  // Debounce: a bit must disagree with the stable level for DEBOUNCE_CYCLES
  // consecutive clocks before the stable level follows it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 6; i++) begin
      db_cnt_d[i] = '0;
      if (in_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = in_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Opposite directions pressed together cancel out; fire bits pass through.
  always_comb begin
    clean = stable_q;
    if (!stable_q[JOY_UP] && !stable_q[JOY_DOWN]) begin
      clean[JOY_UP]   = 1'b1;
      clean[JOY_DOWN] = 1'b1;
    end
    if (!stable_q[JOY_LEFT] && !stable_q[JOY_RIGHT]) begin
      clean[JOY_LEFT]  = 1'b1;
      clean[JOY_RIGHT] = 1'b1;
    end
  end

  // Autofire: held at count 0 / PRESS whenever it is idle, so both a fresh press
  // and an enable arriving mid-hold start with an immediate shot.
  always_comb begin
    af_cnt_d   = af_cnt_q + AfW'(1);
    af_phase_d = af_phase_q;
    if (!af_en || stable_q[JOY_FIRE]) begin
      af_cnt_d   = '0;
      af_phase_d = AfPress;
    end else if (af_cnt_q == AfLast) begin
      af_cnt_d   = '0;
      af_phase_d = (af_phase_q == AfPress) ? AfRelease : AfPress;
    end
  end

  always_comb begin
    cond = clean;
    if (af_en && !stable_q[JOY_FIRE]) begin
      cond[JOY_FIRE] = (af_phase_q == AfRelease);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q       <= 6'h3F;
      stable_q   <= 6'h3F;
      af_cnt_q   <= '0;
      af_phase_q <= AfPress;
      for (int i = 0; i < 6; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      in_q       <= joy_in;
      stable_q   <= stable_d;
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
      for (int i = 0; i < 6; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/joy_conditioner.sv
// Conditions both raw joystick ports for the Minimig JOYA/JOYB inputs.
// Ports:
//   clk          in   system clock (clk_28 domain), the only clock
//   rst          in   synchronous reset, active-high
//   joya_in      in   6 raw port A bits, active-low
//   joyb_in      in   6 raw port B bits, active-low
//   autofire_en  in   2 [0] port A, [1] port B; affects the fire bit only
//   swap         in   1 = exchange the conditioned ports on the outputs
//   joya_out     out  7 to core JOYA, active-low, bit 6 tied 1
//   joyb_out     out  7 to core JOYB, active-low, bit 6 tied 1
//   changed      out  one-cycle pulse after {joya_out, joyb_out} takes a new value
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 28375,
  parameter int unsigned AF_HALF         = 709375
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] joya_in,
  input  logic [5:0] joyb_in,
  input  logic [1:0] autofire_en,
  input  logic       swap,
  output logic [6:0] joya_out,
  output logic [6:0] joyb_out,
  output logic       changed
);

  logic [5:0] cond_a, cond_b;
  logic [6:0] joya_q, joya_d, joyb_q, joyb_d;
  logic [6:0] prev_a_q, prev_b_q;
  logic       changed_q;

  joy_port_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .AF_HALF        (AF_HALF)
  ) u_port_a (
    .clk   (clk),
    .rst   (rst),
    .joy_in(joya_in),
    .af_en (autofire_en[0]),
    .cond  (cond_a)
  );

  joy_port_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .AF_HALF        (AF_HALF)
  ) u_port_b (
    .clk   (clk),
    .rst   (rst),
    .joy_in(joyb_in),
    .af_en (autofire_en[1]),
    .cond  (cond_b)
  );

  always_comb begin
    joya_d = {1'b1, swap ? cond_b : cond_a};
    joyb_d = {1'b1, swap ? cond_a : cond_b};
  end

  // changed compares the output register against its own previous value, so it
  // pulses on the cycle after the outputs update.
  always_ff @(posedge clk) begin
    if (rst) begin
      joya_q    <= JOY_IDLE;
      joyb_q    <= JOY_IDLE;
      prev_a_q  <= JOY_IDLE;
      prev_b_q  <= JOY_IDLE;
      changed_q <= 1'b0;
    end else begin
      joya_q    <= joya_d;
      joyb_q    <= joyb_d;
      prev_a_q  <= joya_q;
      prev_b_q  <= joyb_q;
      changed_q <= ({joya_q, joyb_q} != {prev_a_q, prev_b_q});
    end
  end

  assign joya_out = joya_q;
  assign joyb_out = joyb_q;
  assign changed  = changed_q;

endmodule
